// File: rtl/fp32_div_seq_if.sv
// Start/done handshake plus operand and result buses between the register block and the divider.
interface fp32_div_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  flags;

  modport master (output start, a, b, input busy, done, result, flags);
  modport slave  (input start, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fp32_div_seq.sv
// Iterative fp32 divider (FTZ, RNE): fixed 29-cycle start-to-done latency, one operation at a time.
// A start while busy or in the done cycle is dropped; there is no queuing.
module fp32_div_seq #(
  parameter int IO_W = 8,
  parameter int ITER = 26
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  fp32_div_seq_if.slave   bus,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_DIVIDE = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] K_NORM = 2'd0;
  localparam logic [1:0] K_NAN  = 2'd1;
  localparam logic [1:0] K_INF  = 2'd2;
  localparam logic [1:0] K_ZERO = 2'd3;

  logic [2:0]        state;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic              sign_q;
  logic [1:0]        kind_q;
  logic              dz_q;
  logic signed [9:0] e_q;
  logic [23:0]       mb_q;
  logic [25:0]       rem_q;
  logic [25:0]       quo_q;
  logic [4:0]        cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [31:0]       res_q;
  logic [3:0]        flg_q;
  logic [IO_W-1:0]   io_q;
  logic [IO_W-1:0]   oeb_q;

  // Unpack and classify
  logic [7:0]        ea;
  logic [7:0]        eb;
  logic [23:0]       ma;
  logic [23:0]       mb;
  logic              a_zero;
  logic              b_zero;
  logic              a_inf;
  logic              b_inf;
  logic              a_nan;
  logic              b_nan;
  logic              pre_shift;
  logic signed [9:0] e_unp;
  logic [1:0]        kind_unp;
  logic              dz_unp;

  always_comb begin
    ea        = a_q[30:23];
    eb        = b_q[30:23];
    ma        = {1'b1, a_q[22:0]};
    mb        = {1'b1, b_q[22:0]};
    a_zero    = (ea == 8'd0);
    b_zero    = (eb == 8'd0);
    a_inf     = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf     = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    a_nan     = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan     = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    // Pre-normalising the dividend keeps the quotient in [1,2), so its MSB is always the hidden bit
    pre_shift = (ma < mb);
    e_unp     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127
              - (pre_shift ? 10'sd1 : 10'sd0);
    kind_unp  = K_NORM;
    dz_unp    = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      kind_unp = K_NAN;
    end else if (a_inf) begin
      kind_unp = K_INF;
    end else if (b_zero) begin
      kind_unp = K_INF;
      dz_unp   = 1'b1;
    end else if (a_zero || b_inf) begin
      kind_unp = K_ZERO;
    end
  end

  // One restoring-division step
  logic [25:0] mb_ext;
  logic        ge;
  logic [24:0] diff;

  always_comb begin
    mb_ext = {2'b00, mb_q};
    ge     = (rem_q >= mb_ext);
    diff   = ge ? 25'(rem_q - mb_ext) : rem_q[24:0];
  end

  // Round, renormalise and range-check
  logic [23:0]       sig;
  logic              guard;
  logic              rnd;
  logic              sticky;
  logic              rnd_up;
  logic [24:0]       sig_r;
  logic [22:0]       frac_r;
  logic signed [9:0] e_r;
  logic [31:0]       res_n;
  logic [3:0]        flg_n;

  always_comb begin
    sig    = quo_q[25:2];
    guard  = quo_q[1];
    rnd    = quo_q[0];
    sticky = |rem_q;
    rnd_up = guard && (rnd || sticky || sig[0]);
    sig_r  = {1'b0, sig} + {24'd0, rnd_up};
    if (sig_r[24]) begin
      frac_r = sig_r[23:1];
      e_r    = e_q + 10'sd1;
    end else begin
      frac_r = sig_r[22:0];
      e_r    = e_q;
    end
    res_n = {sign_q, 31'd0};
    flg_n = 4'b0000;
    case (kind_q)
      K_NAN: begin
        res_n = 32'h7FC0_0000;
        flg_n = 4'b1000;
      end
      K_INF: begin
        res_n = {sign_q, 8'hFF, 23'd0};
        flg_n = {1'b0, dz_q, 2'b00};
      end
      K_ZERO: begin
        res_n = {sign_q, 31'd0};
      end
      default: begin
        if (e_r >= 10'sd255) begin
          res_n = {sign_q, 8'hFF, 23'd0};
          flg_n = 4'b0010;
        end else if (e_r <= 10'sd0) begin
          res_n = {sign_q, 31'd0};
          flg_n = 4'b0001;
        end else begin
          res_n = {sign_q, e_r[7:0], frac_r};
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      kind_q <= K_NORM;
      dz_q   <= 1'b0;
      e_q    <= '0;
      mb_q   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
      flg_q  <= '0;
      io_q   <= '0;
      oeb_q  <= '1;
    end else begin
      oeb_q <= '0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            busy_q <= 1'b1;
            state  <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q <= a_q[31] ^ b_q[31];
          kind_q <= kind_unp;
          dz_q   <= dz_unp;
          e_q    <= e_unp;
          mb_q   <= mb;
          rem_q  <= pre_shift ? {1'b0, ma, 1'b0} : {2'b00, ma};
          quo_q  <= '0;
          cnt_q  <= '0;
          state  <= S_DIVIDE;
        end
        S_DIVIDE: begin
          rem_q <= {diff, 1'b0};
          quo_q <= {quo_q[24:0], ge};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          res_q  <= res_n;
          flg_q  <= flg_n;
          io_q   <= res_n[IO_W-1:0];
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;
  assign bus.flags  = flg_q;
  assign io_out     = io_q;
  assign io_oeb     = oeb_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed bench for fp32_div_seq: exact-integer reference divider, per-cycle done checker, literal pins.
module tb_fp32_div_seq;
  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic [7:0] io_out;
  logic [7:0] io_oeb;

  fp32_div_seq_if bus ();

  fp32_div_seq #(.IO_W(8), .ITER(26)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus),
    .io_out   (io_out),
    .io_oeb   (io_oeb)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] last_res;
  logic [3:0]  last_flg;
  logic [7:0]  last_io;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer quotient of the significands, then IEEE round-to-nearest-even.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          ex, ey, e;
    logic        xz, yz, xi, yi, xn, yn;
    logic [63:0] num, den, q, rm, low, half, mant;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 23'd0);
    yi = (ey == 255) && (y[22:0] == 23'd0);
    xn = (ex == 255) && (x[22:0] != 23'd0);
    yn = (ey == 255) && (y[22:0] != 23'd0);
    if (xn || yn || (xz && yz) || (xi && yi)) return {4'b1000, 32'h7FC00000};
    if (xi) return {4'b0000, s, 8'hFF, 23'd0};
    if (yz) return {4'b0100, s, 8'hFF, 23'd0};
    if (xz || yi) return {4'b0000, s, 31'd0};
    num = {40'd0, 1'b1, x[22:0]} << 39;
    den = {40'd0, 1'b1, y[22:0]};
    q   = num / den;
    rm  = num % den;
    e   = ex - ey + 127;
    if (q >= (64'd1 << 39)) begin
      mant = q >> 16;
      low  = q & 64'hFFFF;
      half = 64'd1 << 15;
    end else begin
      e    = e - 1;
      mant = q >> 15;
      low  = q & 64'h7FFF;
      half = 64'd1 << 14;
    end
    if (low > half || (low == half && (rm != 0 || mant[0]))) mant = mant + 1;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0001, s, 31'd0};
    return {4'b0000, s, e[7:0], mant[22:0]};
  endfunction

  // Per-cycle checker: done must rise exactly at each expected cycle and nowhere else.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (exp_q.size() > 0 && cyc == exp_q[0].due) begin
        check("done_at_due", bus.done, 1'b1);
        check("result", bus.result, exp_q[0].res);
        check("flags", bus.flags, exp_q[0].flg);
        check("io_out", io_out, exp_q[0].res[7:0]);
        check("busy_in_done", bus.busy, 1'b0);
        last_res = bus.result;
        last_flg = bus.flags;
        last_io  = io_out;
        void'(exp_q.pop_front());
      end else if (bus.done) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: done=1 with result %h at cycle %0d", bus.result, cyc);
      end
    end
  end

  // Drive start for one cycle; the accepting edge is T = cyc+1, done is visible after edge T+28.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input bit accept, output int due);
    logic [35:0] r;
    exp_t        e;
    @(negedge wb_clk_i);
    bus.start = 1'b1;
    bus.a     = x;
    bus.b     = y;
    due       = cyc + 29;
    if (accept) begin
      r     = model(x, y);
      e.due = due;
      e.res = r[31:0];
      e.flg = r[35:32];
      exp_q.push_back(e);
    end
    @(negedge wb_clk_i);
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h1234_5678;
    check("busy_after_start", bus.busy, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge wb_clk_i);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_lit(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] res, input logic [3:0] flg);
    int due;
    issue(x, y, 1'b1, due);
    drain();
    check({name, "_res"}, last_res, res);
    check({name, "_flg"}, last_flg, flg);
  endtask

  logic [31:0] xs [0:7] = '{32'h40490FDB, 32'h3F7FFFFF, 32'h80000000, 32'h3F800000,
                            32'h7F800001, 32'h00000000, 32'h7F800000, 32'hBF800000};
  logic [31:0] ys [0:7] = '{32'h402DF854, 32'h3F7FFFFE, 32'h3F800000, 32'hFF800000,
                            32'h3F800000, 32'h7F800000, 32'h00000000, 32'h00000000};

  initial begin
    int due;
    wb_rst_i  = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge wb_clk_i);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 32'h0);
    check("rst_flags", bus.flags, 4'h0);
    check("rst_io_out", io_out, 8'h00);
    check("rst_io_oeb", io_oeb, 8'hFF);
    wb_rst_i = 1'b0;
    #1;
    check("oeb_before_clock", io_oeb, 8'hFF);
    @(negedge wb_clk_i);
    check("oeb_after_clock", io_oeb, 8'h00);

    run_lit("neg33_pi", 32'hC2040000, 32'h40490FDB, 32'hC128114F, 4'b0000);
    check("neg33_pi_io", last_io, 8'h4F);
    run_lit("one_pi", 32'h3F800000, 32'h40490FDB, 32'h3EA2F983, 4'b0000);
    check("one_pi_io", last_io, 8'h83);
    run_lit("six_two", 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
    run_lit("one_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);
    run_lit("div_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100);
    run_lit("zero_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_lit("ninf_two", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    run_lit("overflow", 32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010);
    run_lit("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 4'b0001);
    run_lit("denormal", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);

    for (int i = 0; i < 8; i++) begin
      issue(xs[i], ys[i], 1'b1, due);
      drain();
    end

    // Second start while busy must be dropped.
    issue(32'h40C00000, 32'h40000000, 1'b1, due);
    repeat (3) @(negedge wb_clk_i);
    issue(32'h3F800000, 32'h40490FDB, 1'b0, due);
    drain();
    check("busy_start_ignored", last_res, 32'h40400000);
    repeat (5) @(negedge wb_clk_i);

    // Start asserted exactly in the done cycle must be dropped.
    issue(32'hC2040000, 32'h40490FDB, 1'b1, due);
    while (cyc < due) @(negedge wb_clk_i);
    bus.start = 1'b1;
    bus.a     = 32'h40C00000;
    bus.b     = 32'h40000000;
    @(negedge wb_clk_i);
    bus.start = 1'b0;
    check("done_cycle_start_busy", bus.busy, 1'b0);
    repeat (35) @(negedge wb_clk_i);

    // Reset mid-operation.
    issue(32'h3F800000, 32'h40490FDB, 1'b1, due);
    repeat (8) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_io_oeb", io_oeb, 8'hFF);
    check("midrst_io_out", io_out, 8'h00);
    check("midrst_result", bus.result, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("midrst_oeb_release", io_oeb, 8'h00);
    repeat (35) @(negedge wb_clk_i);
    run_lit("after_rst", 32'hC2040000, 32'h40490FDB, 32'hC128114F, 4'b0000);
    repeat (5) @(negedge wb_clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
